led_pulse_stretcher: RTL
========================

Name: led_pulse_stretcher

Overview:
- Output-side counterpart to the push-button input conditioning.
- Takes single-cycle event pulses from game logic (hit, miss, ship sunk, turn change) and stretches each one into a human-visible LED blink pattern.
- Each channel is independent: one pulse produces BLINKS on/off cycles of programmable length.
- Sits between the game FSM and the board LED pins.

Parameters:
- CHANNELS, 4: number of independent event/LED channels.
- ON_CYCLES, 25000000: clock cycles the LED is lit per blink; must be >= 1.
- OFF_CYCLES, 12500000: clock cycles the LED is dark between blinks; must be >= 1.
- BLINKS, 3: blinks per event; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserted when 0, released synchronously by design upstream.
- pulse_in  input  CHANNELS  per-channel single-cycle event strobe; a level held high re-triggers every cycle.
- clear  input  1  synchronous abort; returns all channels to idle.
- led_out  output  CHANNELS  registered LED drive, 1 = lit.
- busy  output  CHANNELS  1 while the channel is in ON or OFF.
- done  output  CHANNELS  one-cycle strobe when a channel's sequence completes normally.

Behaviour:
- Reset (rst == 0, asynchronous): every channel goes to IDLE; led_out = 0, busy = 0, done = 0, counters = 0.
- Per-channel FSM states are IDLE, ON, OFF. Internal state: cycle counter cnt, width clog2(max(ON_CYCLES, OFF_CYCLES)); blink counter left, width clog2(BLINKS + 1).
- IDLE:
  - led = 0, busy = 0.
  - pulse_in[i] = 1 -> ON, cnt = 0, left = BLINKS - 1.
- ON:
  - led = 1, busy = 1; cnt increments each cycle.
  - At cnt == ON_CYCLES - 1 and left == 0 -> IDLE, with done[i] = 1 for exactly that next cycle.
  - At cnt == ON_CYCLES - 1 and left != 0 -> OFF, cnt = 0.
- OFF:
  - led = 0, busy = 1; cnt increments each cycle.
  - At cnt == OFF_CYCLES - 1 -> ON, cnt = 0, left = left - 1.
- Latency: a pulse sampled at edge t gives led high from cycle t+1 for exactly ON_CYCLES cycles. Total busy time = BLINKS*ON_CYCLES + (BLINKS-1)*OFF_CYCLES.
- Retrigger: pulse_in[i] in ON or OFF restarts the sequence (ON, cnt = 0, left = BLINKS-1). No done is issued for the aborted sequence.
- If a retrigger lands on the terminal cycle, the retrigger wins and done is not asserted.
- clear = 1: all channels go to IDLE on the next edge with no done strobe. clear overrides a simultaneous pulse_in.
- Channels never interact; simultaneous pulses on several channels are all accepted.
- Counters never wrap. Maximum values are bounded by the terminal compares above.
- Outputs are direct register outputs with no combinational path from inputs.

Decomposition:
- Shared package battleship_ui_pkg holds:
  - the state encoding (IDLE = 2'd0, ON = 2'd1, OFF = 2'd2; 2'd3 decodes to IDLE);
  - the counter-width localparams derived via clog2.
- Sub-module led_pulse_channel implements one channel's FSM and counters.
- The top level is a generate loop of CHANNELS instances sharing clk, rst and clear.

Test Plan (bench parameters: ON_CYCLES = 4, OFF_CYCLES = 2, BLINKS = 2, CHANNELS = 4):
- Reset check: hold rst = 0 mid-sequence -> led_out, busy and done go to 0 immediately and asynchronously. Releasing rst with no pulses keeps all outputs 0.
- Basic sequence: single pulse on ch0 at cycle 0 ->
  - led_out[0] high in cycles 1-4, low in 5-6, high in 7-10;
  - busy[0] high in cycles 1-10;
  - done[0] high only in cycle 11, with led low.
- Retrigger: pulses on ch0 at cycles 0 and 3 ->
  - led high 1-7, low 8-9, high 10-13;
  - done at cycle 14 only;
  - no done near cycle 3.
- Independence: ch1 pulsed at cycle 0 and ch2 at cycle 5 -> each follows the basic timing offset by its own start; ch0 and ch3 stay 0.
- Clear: pulse ch0 at cycle 0, clear at cycle 6 (same cycle as a ch1 pulse) -> from cycle 7 all outputs are 0, no done strobes, and ch1 stays idle.
- Held input: pulse_in[0] held high for 10 cycles -> led_out[0] stays high through cycle 13, then continues the normal sequence with done at cycle 20.

Source files
------------

// File: rtl/battleship_ui_pkg.sv
// Shared definitions for the battleship board UI blocks: per-channel LED
// sequencer state encoding and counter-width helpers.
package battleship_ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } ch_state_e;

    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_ON_CYCLES  = 25_000_000;
    localparam int DEF_OFF_CYCLES = 12_500_000;
    localparam int DEF_BLINKS     = 3;

    // Cycle counter only ever reaches max(on, off) - 1, so clog2 of the
    // larger length is enough; never narrower than one bit.
    function automatic int cnt_width(input int on_cycles, input int off_cycles);
        int longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return ($clog2(longest) < 1) ? 1 : $clog2(longest);
    endfunction

    function automatic int left_width(input int blinks);
        return ($clog2(blinks + 1) < 1) ? 1 : $clog2(blinks + 1);
    endfunction

    localparam int DEF_CNT_W  = cnt_width(DEF_ON_CYCLES, DEF_OFF_CYCLES);
    localparam int DEF_LEFT_W = left_width(DEF_BLINKS);

endpackage

// File: rtl/led_pulse_channel.sv
// One LED channel: turns a single-cycle event strobe into BLINKS on/off
// blinks. Retrigger restarts the sequence; clear aborts it silently.
module led_pulse_channel
    import battleship_ui_pkg::*;
#(
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int BLINKS     = DEF_BLINKS
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    input  logic clear,
    output logic led_out,
    output logic busy,
    output logic done
);

    localparam int CNT_W  = cnt_width(ON_CYCLES, OFF_CYCLES);
    localparam int LEFT_W = left_width(BLINKS);

    localparam logic [CNT_W-1:0]  ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST   = CNT_W'(OFF_CYCLES - 1);
    localparam logic [LEFT_W-1:0] LEFT_START = LEFT_W'(BLINKS - 1);

    ch_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEFT_W-1:0] left_q, left_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case/if tree leaves it unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d = '0;
                    if (left_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (cnt_q == OFF_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    left_d  = left_q - LEFT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // Encoding 2'd3 is unreachable but decodes to idle.
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A retrigger beats the terminal transition, and clear beats both.
        if (pulse_in) begin
            state_d = ST_ON;
            cnt_d   = '0;
            left_d  = LEFT_START;
            done_d  = 1'b0;
        end
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            left_d  = '0;
            done_d  = 1'b0;
        end

        led_d  = (state_d == ST_ON);
        busy_d = (state_d == ST_ON) || (state_d == ST_OFF);
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            left_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign led_out = led_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Bank of independent LED pulse stretchers between the game FSM and the
// board LED pins; one channel per event type.
module led_pulse_stretcher
    import battleship_ui_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int BLINKS     = DEF_BLINKS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] pulse_in,
    input  logic                clear,
    output logic [CHANNELS-1:0] led_out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_pulse_channel #(
            .ON_CYCLES  (ON_CYCLES),
            .OFF_CYCLES (OFF_CYCLES),
            .BLINKS     (BLINKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .pulse_in (pulse_in[i]),
            .clear    (clear),
            .led_out  (led_out[i]),
            .busy     (busy[i]),
            .done     (done[i])
        );
    end

endmodule
